// File: rtl/cordic_vectoring_iterative.sv
// Iterative circular-vectoring CORDIC: returns gain-scaled magnitude and atan2(Y, X)
// in pi/128 units, one micro-rotation per clock over 8 cycles.
module cordic_vectoring_iterative #(
  parameter int N_INT      = 0,
  parameter int N_FRAC     = -7,
  parameter int GUARD_BITS = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 strb_data_valid_i,
  input  logic [N_INT-N_FRAC:0]                X_i,
  input  logic [N_INT-N_FRAC:0]                Y_i,
  output logic [N_INT-N_FRAC+GUARD_BITS:0]     X_o,
  output logic [N_INT-N_FRAC:0]                Z_o,
  output logic                                 strb_data_valid_o,
  output logic                                 busy_o
);

  localparam int BW = N_INT - N_FRAC + 1;
  localparam int XW = BW + GUARD_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t               state_q;
  logic [2:0]           iter_q;
  logic signed [XW-1:0] x_q, y_q;
  logic [BW-1:0]        z_q;

  logic signed [XW-1:0] x_ext, y_ext, x_pre, y_pre;
  logic signed [XW-1:0] x_sh, y_sh, x_nxt, y_nxt;
  logic [BW-1:0]        z_pre, z_nxt, atan_val;

  always_comb begin
    atan_val = '0;
    case (iter_q)
      3'd0: atan_val = BW'(32);
      3'd1: atan_val = BW'(19);
      3'd2: atan_val = BW'(10);
      3'd3: atan_val = BW'(5);
      3'd4: atan_val = BW'(3);
      3'd5: atan_val = BW'(1);
      3'd6: atan_val = BW'(1);
      3'd7: atan_val = BW'(0);
      default: atan_val = '0;
    endcase
  end

  // Quadrant fold into the right half-plane; the guard bits make -(-128) representable.
  always_comb begin
    x_ext = {{GUARD_BITS{X_i[BW-1]}}, X_i};
    y_ext = {{GUARD_BITS{Y_i[BW-1]}}, Y_i};
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (x_ext[XW-1]) begin
      if (!y_ext[XW-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = BW'(64);
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = BW'(-64);
      end
    end
  end

  always_comb begin
    x_sh = x_q >>> iter_q;
    y_sh = y_q >>> iter_q;
    if (!y_q[XW-1]) begin
      x_nxt = x_q + y_sh;
      y_nxt = y_q - x_sh;
      z_nxt = z_q + atan_val;
    end else begin
      x_nxt = x_q - y_sh;
      y_nxt = y_q + x_sh;
      z_nxt = z_q - atan_val;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q           <= IDLE;
      iter_q            <= '0;
      x_q               <= '0;
      y_q               <= '0;
      z_q               <= '0;
      X_o               <= '0;
      Z_o               <= '0;
      strb_data_valid_o <= 1'b0;
    end else begin
      strb_data_valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strb_data_valid_i) begin
            x_q     <= x_pre;
            y_q     <= y_pre;
            z_q     <= z_pre;
            iter_q  <= '0;
            state_q <= ITER;
          end
        end
        ITER: begin
          x_q    <= x_nxt;
          y_q    <= y_nxt;
          z_q    <= z_nxt;
          iter_q <= iter_q + 3'd1;
          if (iter_q == 3'd7) begin
            X_o               <= x_nxt;
            Z_o               <= z_nxt;
            strb_data_valid_o <= 1'b1;
            state_q           <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == ITER);

endmodule

// File: tb/tb_cordic_vectoring_iterative.sv
// Scoreboard bench for cordic_vectoring_iterative: directed vectors plus an
// equation-level reference sweep and an angle-accuracy check.
module tb_cordic_vectoring_iterative;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       strb_data_valid_i;
  logic [7:0] X_i, Y_i;
  logic [9:0] X_o;
  logic [7:0] Z_o;
  logic       strb_data_valid_o;
  logic       busy_o;

  cordic_vectoring_iterative #(
    .N_INT     (0),
    .N_FRAC    (-7),
    .GUARD_BITS(2)
  ) dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .strb_data_valid_i (strb_data_valid_i),
    .X_i               (X_i),
    .Y_i               (Y_i),
    .X_o               (X_o),
    .Z_o               (Z_o),
    .strb_data_valid_o (strb_data_valid_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int x;
    int z;
    int cyc;
    int xi;
    int yi;
    bit ang;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: unbounded integer arithmetic straight from the iteration equations.
  function automatic void ref_model(input int xi, input int yi, output int xo, output int zo);
    int at[8] = '{32, 19, 10, 5, 3, 1, 1, 0};
    int x, y, z, nx, ny;
    if (xi >= 0) begin
      x = xi; y = yi; z = 0;
    end else if (yi >= 0) begin
      x = yi; y = -xi; z = 64;
    end else begin
      x = -yi; y = xi; z = -64;
    end
    for (int i = 0; i < 8; i++) begin
      if (y >= 0) begin
        nx = x + (y >>> i); ny = y - (x >>> i); z = z + at[i];
      end else begin
        nx = x - (y >>> i); ny = y + (x >>> i); z = z - at[i];
      end
      x = nx; y = ny;
    end
    xo = x;
    zo = z & 255;
    if (zo >= 128) zo -= 256;
  endfunction

  // Monitor: every result strobe must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rstn_i && strb_data_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("X_o", int'($signed(X_o)), e.x);
        chk("Z_o", int'($signed(Z_o)), e.z);
        chk("valid_cycle", cyc, e.cyc);
        if (e.ang) begin
          real pi, d;
          pi = 3.14159265358979;
          d  = real'(int'($signed(Z_o))) * pi / 128.0 - $atan2(real'(e.yi), real'(e.xi));
          while (d > pi)  d -= 2.0 * pi;
          while (d < -pi) d += 2.0 * pi;
          chk("angle_err_ok", (d < 0.1 && d > -0.1) ? 1 : 0, 1);
        end
      end
    end
  end

  // Called just after a negedge; the start is sampled at the next posedge.
  task automatic drive_start(input int x, input int y, input bit push, input int ex,
                             input int ez, input bit ang);
    exp_t e;
    X_i = 8'(x);
    Y_i = 8'(y);
    strb_data_valid_i = 1'b1;
    if (push) begin
      e.x = ex; e.z = ez; e.cyc = cyc + 9; e.xi = x; e.yi = y; e.ang = ang;
      sb.push_back(e);
    end
    @(negedge clk_i);
    strb_data_valid_i = 1'b0;
  endtask

  task automatic model_start(input int x, input int y);
    int ex, ez;
    bit ang;
    ref_model(x, y, ex, ez);
    ang = (x * x + y * y) >= 32 * 32;
    drive_start(x, y, 1'b1, ex, ez, ang);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cx[6] = '{-128, -128, 127, -128, 0, 127};
    int cy[6] = '{-128, 127, -128, 0, -128, 127};
    int c0;

    rstn_i = 1'b0;
    strb_data_valid_i = 1'b0;
    X_i = '0;
    Y_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_X_o", int'(X_o), 0);
    chk("rst_Z_o", int'(Z_o), 0);
    chk("rst_valid", int'(strb_data_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // (64,0): hand-derived 106 / +1; busy for the 8 cycles after the start edge.
    drive_start(64, 0, 1'b1, 106, 1, 1'b0);
    chk("busy_iter", int'(busy_o), 1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk_i);
      chk("busy_iter", int'(busy_o), 1);
    end
    @(negedge clk_i);
    chk("busy_strobe_cycle", int'(busy_o), 0);
    repeat (2) @(negedge clk_i);

    // (-64,0): pre-rotation and Z wrap past +127.
    drive_start(-64, 0, 1'b1, 108, 127, 1'b0);
    repeat (10) @(negedge clk_i);

    // (0,0): every decision takes the Y >= 0 branch, Z = sum of table = 71.
    drive_start(0, 0, 1'b1, 0, 71, 1'b0);
    repeat (10) @(negedge clk_i);

    // Strobe 3 cycles after the start is ignored.
    drive_start(64, 0, 1'b1, 106, 1, 1'b0);
    repeat (2) @(negedge clk_i);
    drive_start(0, 0, 1'b0, 0, 0, 1'b0);
    repeat (12) @(negedge clk_i);

    // Start in the result-strobe cycle is accepted: results 9 cycles apart.
    drive_start(-64, 0, 1'b1, 108, 127, 1'b0);
    repeat (8) @(negedge clk_i);
    chk("valid_in_strobe_cycle", int'(strb_data_valid_o), 1);
    drive_start(0, 0, 1'b1, 0, 71, 1'b0);
    repeat (10) @(negedge clk_i);

    // Continuously-held strobe restarts on each return to IDLE.
    c0 = cyc;
    X_i = 8'(64);
    Y_i = 8'(0);
    strb_data_valid_i = 1'b1;
    sb.push_back('{106, 1, c0 + 9, 64, 0, 1'b0});
    sb.push_back('{106, 1, c0 + 18, 64, 0, 1'b0});
    repeat (18) @(negedge clk_i);
    strb_data_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Asynchronous reset mid-iteration aborts without a result strobe.
    drive_start(-64, 0, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    chk("abort_X_o", int'(X_o), 0);
    chk("abort_Z_o", int'(Z_o), 0);
    chk("abort_valid", int'(strb_data_valid_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (12) @(negedge clk_i);
    drive_start(64, 0, 1'b1, 106, 1, 1'b0);
    repeat (10) @(negedge clk_i);

    // Back-to-back sweep: corners first, then random pairs, checked by the reference model.
    for (int n = 0; n < 1000; n++) begin
      int x, y;
      if (n < 6) begin
        x = cx[n];
        y = cy[n];
      end else begin
        x = int'($urandom_range(0, 255)) - 128;
        y = int'($urandom_range(0, 255)) - 128;
      end
      model_start(x, y);
      repeat (8) @(negedge clk_i);
    end

    for (int w = 0; w < 30 && sb.size() != 0; w++) @(negedge clk_i);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
